// File: rtl/message_pkg.sv
// Shared definitions for the message stream splitter and combiner.
// Holds the header field positions, the splitter FSM state type and the
// header range check used by the header decoder.
package message_pkg;

   // Header field positions, counted down from the word MSB.
   // The flag is the MSB; the stream index sits directly below it.
   localparam int unsigned HDR_FLAG_FROM_MSB  = 0;
   localparam int unsigned HDR_INDEX_FROM_MSB = 1;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      PAYLOAD = 1'b1
   } state_t;

   // Mask that keeps the length field (the low log_len bits of a header).
   function automatic logic [31:0] length_mask(input int unsigned log_len);
      return (32'd1 << log_len) - 32'd1;
   endfunction

   // True when the header fields name an existing stream and a legal length.
   function automatic logic header_in_range(input int unsigned index,
                                            input int unsigned length,
                                            input int unsigned n_streams,
                                            input int unsigned max_len);
      return (index < n_streams) && (length <= max_len);
   endfunction

endpackage

// File: rtl/message_stream_splitter_if.sv
// Bus bundle for the message stream splitter: one combined input stream
// and N_STREAMS output lanes plus the sticky error flag.
interface message_stream_splitter_if #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned N_STREAMS = 4
);

   // Handshake: valid-only, no ready. in_nd qualifies in_data in the cycle it
   // is high and the word is always consumed; out_nd[k] qualifies lane k of
   // out_data for exactly one cycle, with at most one bit set per cycle.
   logic [WIDTH-1:0]           in_data;
   logic                       in_nd;
   logic [WIDTH*N_STREAMS-1:0] out_data;
   logic [N_STREAMS-1:0]       out_nd;
   logic                       error;

   modport master (
      output in_data,
      output in_nd,
      input  out_data,
      input  out_nd,
      input  error
   );

   modport slave (
      input  in_data,
      input  in_nd,
      output out_data,
      output out_nd,
      output error
   );

endinterface

// File: rtl/message_header_decoder.sv
// Combinational header field extractor. Splits a word into its header flag,
// stream index and payload length, and reports whether index and length are
// within range. `valid` covers only the field ranges; callers combine it
// with `is_header`.
module message_header_decoder
   import message_pkg::*;
#(
   parameter int unsigned N_STREAMS             = 4,
   parameter int unsigned LOG_N_STREAMS         = 2,
   parameter int unsigned WIDTH                 = 32,
   parameter int unsigned MAX_PACKET_LENGTH     = 127,
   parameter int unsigned LOG_MAX_PACKET_LENGTH = 7
) (
   input  logic [WIDTH-1:0]                 word,
   output logic                             is_header,
   output logic [LOG_N_STREAMS-1:0]         index,
   output logic [LOG_MAX_PACKET_LENGTH-1:0] length,
   output logic                             valid
);

   localparam int unsigned FLAG_POS  = WIDTH - 1 - HDR_FLAG_FROM_MSB;
   localparam int unsigned INDEX_TOP = WIDTH - 1 - HDR_INDEX_FROM_MSB;

   logic [WIDTH-1:0] length_bits;
   // Reserved header bits are not decoded; fold them here so they count as read.
   logic             unused_word;

   assign is_header   = word[FLAG_POS];
   assign index       = word[INDEX_TOP -: LOG_N_STREAMS];
   assign length_bits = word & WIDTH'(length_mask(LOG_MAX_PACKET_LENGTH));
   assign length      = length_bits[LOG_MAX_PACKET_LENGTH-1:0];
   assign valid       = header_in_range(32'(index), 32'(length),
                                        N_STREAMS, MAX_PACKET_LENGTH);
   assign unused_word = ^{word, length_bits};

endmodule

// File: rtl/message_stream_splitter.sv
// Message stream splitter: routes each packet (header + L payload words) of
// a combined stream to the output lane named by the header's stream index.
// One-cycle registered latency, no backpressure, sticky protocol error.
// Build option: MESSAGE_STREAM_SPLITTER_STRIP_HEADER_EN consumes accepted
// headers instead of forwarding them; payload timing is unchanged.
module message_stream_splitter
   import message_pkg::*;
#(
   parameter int unsigned N_STREAMS             = 4,
   parameter int unsigned LOG_N_STREAMS         = 2,
   parameter int unsigned WIDTH                 = 32,
   parameter int unsigned MAX_PACKET_LENGTH     = 127,
   parameter int unsigned LOG_MAX_PACKET_LENGTH = 7
) (
   input  logic                       clk,
   input  logic                       reset,
   message_stream_splitter_if.slave   bus,
   output state_t                     state
);

`ifdef MESSAGE_STREAM_SPLITTER_STRIP_HEADER_EN
   localparam bit STRIP_HEADER = 1'b1;
`else
   localparam bit STRIP_HEADER = 1'b0;
`endif

   state_t                           state_q, state_d;
   logic [LOG_N_STREAMS-1:0]         sel_q, sel_d;
   logic [LOG_MAX_PACKET_LENGTH-1:0] remaining_q, remaining_d;

   logic                             hdr_is_header;
   logic [LOG_N_STREAMS-1:0]         hdr_index;
   logic [LOG_MAX_PACKET_LENGTH-1:0] hdr_length;
   logic                             hdr_valid;

   logic                             emit;
   logic [LOG_N_STREAMS-1:0]         emit_lane;
   logic                             set_error;
   logic [N_STREAMS-1:0]             lane_hit;

   logic [WIDTH*N_STREAMS-1:0]       out_data_q;
   logic [N_STREAMS-1:0]             out_nd_q;
   logic                             error_q;

   message_header_decoder #(
      .N_STREAMS             (N_STREAMS),
      .LOG_N_STREAMS         (LOG_N_STREAMS),
      .WIDTH                 (WIDTH),
      .MAX_PACKET_LENGTH     (MAX_PACKET_LENGTH),
      .LOG_MAX_PACKET_LENGTH (LOG_MAX_PACKET_LENGTH)
   ) u_decoder (
      .word      (bus.in_data),
      .is_header (hdr_is_header),
      .index     (hdr_index),
      .length    (hdr_length),
      .valid     (hdr_valid)
   );

   // FSM state, latched stream and payload countdown; reset aborts any packet.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         remaining_q <= remaining_d;
      end
   end

   // Next state and per-word routing decision; idle cycles change nothing.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      remaining_d = remaining_q;
      emit        = 1'b0;
      emit_lane   = sel_q;
      set_error   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.in_nd) begin
               if (hdr_is_header && hdr_valid) begin
                  emit      = !STRIP_HEADER;
                  emit_lane = hdr_index;
                  if (hdr_length != '0) begin
                     state_d     = PAYLOAD;
                     sel_d       = hdr_index;
                     remaining_d = hdr_length;
                  end
               end else begin
                  // Stray payload or out-of-range header: drop and flag.
                  set_error = 1'b1;
               end
            end
         end
         PAYLOAD: begin
            if (bus.in_nd) begin
               emit        = 1'b1;
               remaining_d = remaining_q - LOG_MAX_PACKET_LENGTH'(1);
               if (remaining_q == LOG_MAX_PACKET_LENGTH'(1)) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // One-hot lane select for the word being emitted this cycle.
   always_comb begin
      lane_hit = '0;
      for (int k = 0; k < int'(N_STREAMS); k++) begin
         lane_hit[k] = emit && (emit_lane == LOG_N_STREAMS'(k));
      end
   end

   // Output registers: selected lane loads the word, others hold; error is sticky.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_data_q <= '0;
         out_nd_q   <= '0;
         error_q    <= 1'b0;
      end else begin
         out_nd_q <= lane_hit;
         error_q  <= error_q | set_error;
         for (int k = 0; k < int'(N_STREAMS); k++) begin
            if (lane_hit[k]) begin
               out_data_q[k*WIDTH +: WIDTH] <= bus.in_data;
            end
         end
      end
   end

   assign bus.out_data = out_data_q;
   assign bus.out_nd   = out_nd_q;
   assign bus.error    = error_q;
   assign state        = state_q;

endmodule
